// File: rtl/cart_loader_pkg.sv
// Shared types and A78 header layout for the cart/BIOS download loader.
package cart_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_CART,
        LOAD_BIOS,
        FINISH,
        MASK,
        DONE
    } state_t;

    // "ATARI", first character at header byte 1
    localparam logic [39:0] MAGIC = 40'h41_54_41_52_49;

    localparam int MAGIC_LO   = 1;
    localparam int MAGIC_HI   = 5;
    localparam int SIZE_OFS   = 49;
    localparam int FLAGS_OFS  = 53;
    localparam int JOY0_OFS   = 55;
    localparam int JOY1_OFS   = 56;
    localparam int REGION_OFS = 57;
    localparam int SAVE_OFS   = 58;

endpackage

// File: rtl/cart_loader_if.sv
// ioctl download stream in, RAM write ports and load results out.
interface cart_loader_if #(
    parameter int ADDR_W      = 18,
    parameter int BIOS_ADDR_W = 12
);
    logic                   ioctl_download;
    logic [7:0]             ioctl_index;
    logic [24:0]            ioctl_addr;
    logic [7:0]             ioctl_dout;
    logic                   ioctl_wr;

    logic [ADDR_W-1:0]      rom_addr;
    logic [7:0]             rom_data;
    logic                   rom_we;
    logic [BIOS_ADDR_W-1:0] bios_addr;
    logic                   bios_we;
    logic [31:0]            cart_size;
    logic [ADDR_W-1:0]      cart_mask;
    logic [15:0]            cart_flags;
    logic [7:0]             joy0_type;
    logic [7:0]             joy1_type;
    logic [7:0]             cart_region;
    logic [7:0]             cart_save;
    logic                   cart_is_7800;
    logic                   hdr_size_mismatch;
    logic                   oversize;
    logic                   busy;
    logic                   load_done;
    logic                   initial_pause;

    modport master (
        input  ioctl_download, ioctl_index, ioctl_addr, ioctl_dout, ioctl_wr,
        output rom_addr, rom_data, rom_we, bios_addr, bios_we,
               cart_size, cart_mask, cart_flags, joy0_type, joy1_type,
               cart_region, cart_save, cart_is_7800, hdr_size_mismatch,
               oversize, busy, load_done, initial_pause
    );

    modport slave (
        output ioctl_download, ioctl_index, ioctl_addr, ioctl_dout, ioctl_wr,
        input  rom_addr, rom_data, rom_we, bios_addr, bios_we,
               cart_size, cart_mask, cart_flags, joy0_type, joy1_type,
               cart_region, cart_save, cart_is_7800, hdr_size_mismatch,
               oversize, busy, load_done, initial_pause
    );
endinterface

// File: rtl/cart_loader_mask_gen.sv
// Iterative mirror-mask builder: grows 2^k-1 until it covers i_size or saturates.
module cart_mask_gen #(
    parameter int ADDR_W = 18
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              i_start,
    input  logic [31:0]       i_size,
    output logic [ADDR_W-1:0] o_mask,
    output logic              o_done
);
    logic [ADDR_W-1:0] r_m;
    logic              r_run;
    logic [32:0]       w_span;
    logic              w_grow;

    // 33 bits so an all-ones mask + 1 cannot wrap
    assign w_span = 33'(r_m) + 33'd1;
    assign w_grow = (w_span < {1'b0, i_size}) && (r_m != '1);
    assign o_mask = r_m;
    assign o_done = r_run && !w_grow;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_m   <= '0;
            r_run <= 1'b0;
        end else if (i_start) begin
            r_m   <= '0;
            r_run <= 1'b1;
        end else if (r_run) begin
            if (w_grow) r_m   <= {r_m[ADDR_W-2:0], 1'b1};
            else        r_run <= 1'b0;
        end
    end
endmodule

// File: rtl/cart_loader.sv
// Streams ioctl downloads into cart/BIOS RAM, strips the A78 header and
// derives size, mirror mask and header fields; holds the core until first load.
module cart_loader
    import cart_loader_pkg::*;
#(
    parameter int         ADDR_W      = 18,
    parameter int         BIOS_ADDR_W = 12,
    parameter int         HDR_LEN     = 128,
    parameter logic [7:0] BIOS_INDEX  = 8'd0
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    cart_loader_if.master bus
);
    state_t r_state, w_next;

    logic [39:0]            r_magic;
    logic [31:0]            r_hdr_size;
    logic [15:0]            r_flags;
    logic [7:0]             r_joy0, r_joy1, r_region, r_save;
    logic [24:0]            r_last_addr;
    logic                   r_seen;
    logic [31:0]            r_cart_size;
    logic [ADDR_W-1:0]      r_cart_mask;
    logic                   r_mismatch, r_oversize, r_pause;
    logic [ADDR_W-1:0]      r_rom_addr;
    logic [7:0]             r_rom_data;
    logic                   r_rom_we;
    logic [BIOS_ADDR_W-1:0] r_bios_addr;
    logic                   r_bios_we;

    logic              w_is_7800, w_cart_start, w_cart_wr, w_bios_wr;
    logic [24:0]       w_tgt;
    logic              w_skip, w_over;
    logic [31:0]       w_total, w_size;
    logic [ADDR_W-1:0] w_mask;
    logic              w_mask_done;

    assign w_is_7800    = (r_magic == MAGIC);
    assign w_cart_start = (r_state == IDLE) && bus.ioctl_download && (bus.ioctl_index != BIOS_INDEX);
    assign w_cart_wr    = (r_state == LOAD_CART) && bus.ioctl_wr;
    assign w_bios_wr    = (r_state == LOAD_BIOS) && bus.ioctl_wr;

    // Magic bytes always land at their raw address; the rest of the header is dropped
    always_comb begin
        w_tgt  = bus.ioctl_addr;
        w_skip = 1'b0;
        if (bus.ioctl_addr > 25'(MAGIC_HI) && w_is_7800) begin
            if (bus.ioctl_addr < 25'(HDR_LEN)) w_skip = 1'b1;
            else                               w_tgt  = bus.ioctl_addr - 25'(HDR_LEN);
        end
    end
    assign w_over = (w_tgt >= (25'd1 << ADDR_W));

    assign w_total = {7'd0, r_last_addr} + 32'd1;
    always_comb begin
        w_size = '0;
        if (r_seen) begin
            if (!w_is_7800)                   w_size = w_total;
            else if (w_total > 32'(HDR_LEN))  w_size = w_total - 32'(HDR_LEN);
        end
    end

    cart_mask_gen #(.ADDR_W(ADDR_W)) u_mask (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .i_start (r_state == FINISH),
        .i_size  (r_cart_size),
        .o_mask  (w_mask),
        .o_done  (w_mask_done)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (bus.ioctl_download)
                           w_next = (bus.ioctl_index == BIOS_INDEX) ? LOAD_BIOS : LOAD_CART;
            LOAD_CART: if (!bus.ioctl_download) w_next = FINISH;
            LOAD_BIOS: if (!bus.ioctl_download) w_next = IDLE;
            FINISH:    w_next = MASK;
            MASK:      if (w_mask_done) w_next = DONE;
            DONE:      w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_magic     <= '0;
            r_hdr_size  <= '0;
            r_flags     <= '0;
            r_joy0      <= '0;
            r_joy1      <= '0;
            r_region    <= '0;
            r_save      <= '0;
            r_last_addr <= '0;
            r_seen      <= 1'b0;
            r_cart_size <= '0;
            r_cart_mask <= '0;
            r_mismatch  <= 1'b0;
            r_oversize  <= 1'b0;
            r_pause     <= 1'b1;
            r_rom_addr  <= '0;
            r_rom_data  <= '0;
            r_rom_we    <= 1'b0;
            r_bios_addr <= '0;
            r_bios_we   <= 1'b0;
        end else begin
            r_rom_we  <= 1'b0;
            r_bios_we <= 1'b0;
            if (w_cart_wr || w_bios_wr) r_rom_data <= bus.ioctl_dout;
            if (w_bios_wr) begin
                r_bios_we   <= 1'b1;
                r_bios_addr <= bus.ioctl_addr[BIOS_ADDR_W-1:0];
            end
            if (w_cart_start) begin
                r_magic     <= '0;
                r_hdr_size  <= '0;
                r_flags     <= '0;
                r_joy0      <= '0;
                r_joy1      <= '0;
                r_region    <= '0;
                r_save      <= '0;
                r_last_addr <= '0;
                r_seen      <= 1'b0;
                r_cart_size <= '0;
                r_cart_mask <= '0;
                r_mismatch  <= 1'b0;
                r_oversize  <= 1'b0;
            end
            if (w_cart_wr) begin
                r_seen      <= 1'b1;
                r_last_addr <= bus.ioctl_addr;
                case (bus.ioctl_addr)
                    25'(MAGIC_LO):     r_magic[39:32]    <= bus.ioctl_dout;
                    25'(MAGIC_LO + 1): r_magic[31:24]    <= bus.ioctl_dout;
                    25'(MAGIC_LO + 2): r_magic[23:16]    <= bus.ioctl_dout;
                    25'(MAGIC_LO + 3): r_magic[15:8]     <= bus.ioctl_dout;
                    25'(MAGIC_HI):     r_magic[7:0]      <= bus.ioctl_dout;
                    25'(SIZE_OFS):     r_hdr_size[31:24] <= bus.ioctl_dout;
                    25'(SIZE_OFS + 1): r_hdr_size[23:16] <= bus.ioctl_dout;
                    25'(SIZE_OFS + 2): r_hdr_size[15:8]  <= bus.ioctl_dout;
                    25'(SIZE_OFS + 3): r_hdr_size[7:0]   <= bus.ioctl_dout;
                    25'(FLAGS_OFS):    r_flags[15:8]     <= bus.ioctl_dout;
                    25'(FLAGS_OFS + 1):r_flags[7:0]      <= bus.ioctl_dout;
                    25'(JOY0_OFS):     r_joy0            <= bus.ioctl_dout;
                    25'(JOY1_OFS):     r_joy1            <= bus.ioctl_dout;
                    25'(REGION_OFS):   r_region          <= bus.ioctl_dout;
                    25'(SAVE_OFS):     r_save            <= bus.ioctl_dout;
                    default: ;
                endcase
                if (!w_skip) begin
                    if (w_over) r_oversize <= 1'b1;
                    else begin
                        r_rom_we   <= 1'b1;
                        r_rom_addr <= w_tgt[ADDR_W-1:0];
                    end
                end
            end
            if (r_state == FINISH) begin
                r_cart_size <= w_size;
                r_mismatch  <= w_is_7800 && (r_hdr_size != w_size);
            end
            if (r_state == MASK && w_mask_done) r_cart_mask <= w_mask;
            if (r_state == DONE) r_pause <= 1'b0;
        end
    end

    assign bus.rom_addr          = r_rom_addr;
    assign bus.rom_data          = r_rom_data;
    assign bus.rom_we            = r_rom_we;
    assign bus.bios_addr         = r_bios_addr;
    assign bus.bios_we           = r_bios_we;
    assign bus.cart_size         = r_cart_size;
    assign bus.cart_mask         = r_cart_mask;
    assign bus.cart_flags        = r_flags;
    assign bus.joy0_type         = r_joy0;
    assign bus.joy1_type         = r_joy1;
    assign bus.cart_region       = r_region;
    assign bus.cart_save         = r_save;
    assign bus.cart_is_7800      = w_is_7800;
    assign bus.hdr_size_mismatch = r_mismatch;
    assign bus.oversize          = r_oversize;
    assign bus.busy              = (r_state != IDLE);
    assign bus.load_done         = (r_state == DONE);
    assign bus.initial_pause     = r_pause;
endmodule
